// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: sequencer state encoding and the fixed instruction size.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: one outstanding imem request, single-entry decode buffer; inst_valid from cycle N+k+1.
// Stalls in HOLD until decode takes the word; redirects flush wrong-path work; watchdog/misalign latch ERR.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_data_o,
    output logic [31:0] inst_pc_o,
    output logic        fetch_err_o
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        drop_q, drop_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic req_fire;
    logic redir_bad;

    assign req_fire  = (state_q == REQ) && !redirect_i && imem_req_ready_i;
    assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ;
            fetch_pc_q  <= RESET_PC;
            drop_q      <= 1'b0;
            wait_cnt_q  <= 8'd0;
            inst_data_q <= 32'd0;
            inst_pc_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_q      <= drop_d;
            wait_cnt_q  <= wait_cnt_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_d      = drop_q;
        wait_cnt_d  = wait_cnt_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;

        case (state_q)
            REQ: begin
                if (req_fire) begin
                    state_d    = WAIT;
                    inst_pc_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + INST_BYTES;
                    wait_cnt_d = 8'd0;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (imem_rsp_valid_i) begin
                    // A redirect landing with the response makes that word wrong-path too.
                    if (drop_q || redirect_i) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_data_d = imem_rsp_data_i;
                        state_d     = HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end else if (wait_cnt_q >= WAIT_LIMIT) begin
                    state_d = ERR;
                end
            end
            HOLD: begin
                if (redirect_i || inst_ready_i) begin
                    state_d = REQ;
                end
            end
            default: begin
            end
        endcase

        if (redirect_i && (state_q != ERR)) begin
            fetch_pc_d = redirect_pc_i;
            if (redir_bad) begin
                state_d = ERR;
            end
        end
    end

    always_comb begin
        imem_req_valid_o = (state_q == REQ) && !redirect_i;
        inst_valid_o     = (state_q == HOLD);
        fetch_err_o      = (state_q == ERR);
    end

    assign imem_req_addr_o = fetch_pc_q;
    assign inst_data_o     = inst_data_q;
    assign inst_pc_o       = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level model plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TO     = 4;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_err;

    fetch_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_data_o      (inst_data),
        .inst_pc_o        (inst_pc),
        .fetch_err_o      (fetch_err)
    );

    int checks;
    int errors;
    int cyc;
    int mem_lat;
    bit mem_dead;

    // Logs of observed handshakes, written by the monitor.
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] cons_pc_q[$];
    logic [31:0] cons_dat_q[$];
    int          cons_cyc_q[$];
    int          due_cyc_q[$];
    logic [31:0] due_addr_q[$];

    // Model state: next expected fetch address, fetched-but-unconsumed PCs, outstanding request.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    bit          m_err;
    bit          m_out;
    int          m_age;

    int          n_req, n_req2, n_cons, c_rel;
    logic [31:0] hold_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_above(input int n, input string name);
        int k;
        k = 0;
        while (req_addr_q.size() <= n && k < 60) begin
            step();
            k++;
        end
        if (req_addr_q.size() <= n) chk(1'b0, name, req_addr_q.size(), n + 1);
    endtask

    task automatic wait_cons_above(input int n, input string name);
        int k;
        k = 0;
        while (cons_pc_q.size() <= n && k < 60) begin
            step();
            k++;
        end
        if (cons_pc_q.size() <= n) chk(1'b0, name, cons_pc_q.size(), n + 1);
    endtask

    task automatic wait_inst_valid(input string name);
        int k;
        k = 0;
        while (!inst_valid && k < 60) begin
            step();
            k++;
        end
        if (!inst_valid) chk(1'b0, name, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: answers each accepted request mem_lat cycles later unless mem_dead.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (due_cyc_q.size() > 0 && due_cyc_q[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memfn(due_addr_q[0]);
                void'(due_cyc_q.pop_front());
                void'(due_addr_q.pop_front());
            end
        end
    end

    // Compare process: outputs sampled at the falling edge, model advanced by this cycle's events.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!redirect) chk(imem_req_valid == 1'b1, "rst_req_valid", 32'(imem_req_valid), 32'd1);
                chk(imem_req_addr == RST_PC, "rst_addr", imem_req_addr, RST_PC);
                chk(inst_valid == 1'b0, "rst_inst_valid", 32'(inst_valid), 32'd0);
                chk(inst_data == 32'd0, "rst_inst_data", inst_data, 32'd0);
                chk(inst_pc == 32'd0, "rst_inst_pc", inst_pc, 32'd0);
                chk(fetch_err == 1'b0, "rst_fetch_err", 32'(fetch_err), 32'd0);
                m_pc  = RST_PC;
                m_pend.delete();
                m_err = 1'b0;
                m_out = 1'b0;
                m_age = 0;
                due_cyc_q.delete();
                due_addr_q.delete();
            end else begin
                if (m_err) begin
                    chk(fetch_err == 1'b1, "err_flag", 32'(fetch_err), 32'd1);
                    chk(imem_req_valid == 1'b0, "err_req_valid", 32'(imem_req_valid), 32'd0);
                    chk(inst_valid == 1'b0, "err_inst_valid", 32'(inst_valid), 32'd0);
                end else begin
                    chk(fetch_err == 1'b0, "no_err", 32'(fetch_err), 32'd0);
                    if (imem_req_valid) begin
                        chk(imem_req_addr == m_pc, "req_addr", imem_req_addr, m_pc);
                        chk(!m_out, "one_outstanding", 32'(m_out), 32'd0);
                    end
                    if (inst_valid) begin
                        chk(imem_req_valid == 1'b0, "no_bypass", 32'(imem_req_valid), 32'd0);
                        chk(!m_out, "valid_after_rsp", 32'(m_out), 32'd0);
                        if (m_pend.size() == 0) begin
                            chk(1'b0, "wrong_path_presented", inst_pc, 32'd0);
                        end else begin
                            chk(inst_pc == m_pend[0], "inst_pc", inst_pc, m_pend[0]);
                            chk(inst_data == memfn(m_pend[0]), "inst_data", inst_data, memfn(m_pend[0]));
                        end
                    end
                end

                if (imem_req_valid && imem_req_ready) begin
                    req_addr_q.push_back(imem_req_addr);
                    req_cyc_q.push_back(cyc);
                    if (!mem_dead) begin
                        due_cyc_q.push_back(cyc + mem_lat);
                        due_addr_q.push_back(imem_req_addr);
                    end
                end
                if (inst_valid && inst_ready && !redirect) begin
                    cons_pc_q.push_back(inst_pc);
                    cons_dat_q.push_back(inst_data);
                    cons_cyc_q.push_back(cyc);
                end

                if (!m_err) begin
                    if (m_out) begin
                        if (imem_rsp_valid) m_out = 1'b0;
                        else m_age++;
                    end
                    if (redirect) begin
                        if (redirect_pc[1:0] != 2'b00) begin
                            m_err = 1'b1;
                        end else begin
                            m_pc = redirect_pc;
                            m_pend.delete();
                        end
                    end else begin
                        if (m_out && m_age >= TO) m_err = 1'b1;
                        if (imem_req_valid && imem_req_ready) begin
                            m_pend.push_back(m_pc);
                            m_pc  = m_pc + 32'd4;
                            m_out = 1'b1;
                            m_age = 0;
                        end
                        if (inst_valid && inst_ready && m_pend.size() > 0) void'(m_pend.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "bench did not complete");
    end

    initial begin
        checks = 0; errors = 0; mem_lat = 1; mem_dead = 1'b0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Stream from reset with a one-cycle memory and a ready decoder.
        wait_cons_above(2, "stream_wait");
        if (cons_pc_q.size() >= 3) begin
            chk(req_addr_q[0] == 32'h100, "req0_addr", req_addr_q[0], 32'h100);
            chk(req_addr_q[1] == 32'h104, "req1_addr", req_addr_q[1], 32'h104);
            chk(req_addr_q[2] == 32'h108, "req2_addr", req_addr_q[2], 32'h108);
            chk(cons_pc_q[0] == 32'h100, "cons0_pc", cons_pc_q[0], 32'h100);
            chk(cons_pc_q[2] == 32'h108, "cons2_pc", cons_pc_q[2], 32'h108);
            chk(cons_dat_q[1] == 32'hC0DE0104, "cons1_data", cons_dat_q[1], 32'hC0DE0104);
            chk(req_cyc_q[1] - req_cyc_q[0] == 3, "fetch_period", req_cyc_q[1] - req_cyc_q[0], 32'd3);
            chk(req_cyc_q[2] - req_cyc_q[1] == 3, "fetch_period2", req_cyc_q[2] - req_cyc_q[1], 32'd3);
            chk(cons_cyc_q[0] - req_cyc_q[0] == 2, "first_latency", cons_cyc_q[0] - req_cyc_q[0], 32'd2);
        end

        // Decoder backpressure for five cycles in HOLD.
        inst_ready = 1'b0;
        wait_inst_valid("bp_wait");
        n_req   = req_addr_q.size();
        hold_pc = cons_pc_q[cons_pc_q.size() - 1] + 32'd4;
        for (int i = 0; i < 5; i++) begin
            chk(inst_valid == 1'b1, "bp_valid", 32'(inst_valid), 32'd1);
            chk(imem_req_valid == 1'b0, "bp_req_valid", 32'(imem_req_valid), 32'd0);
            chk(inst_data == memfn(hold_pc), "bp_data", inst_data, memfn(hold_pc));
            step();
        end
        chk(req_addr_q.size() == n_req, "bp_no_req", req_addr_q.size(), n_req);
        inst_ready = 1'b1;
        c_rel = cyc;
        step();
        wait_req_above(n_req, "bp_req_wait");
        if (req_cyc_q.size() > n_req)
            chk(req_cyc_q[n_req] == c_rel + 1, "bp_next_req_cycle", req_cyc_q[n_req], c_rel + 1);

        // Redirect while a three-cycle response is outstanding.
        mem_lat = 3;
        n_req = req_addr_q.size();
        wait_req_above(n_req, "rw_req_wait");
        redirect = 1'b1; redirect_pc = 32'h200;
        n_cons = cons_pc_q.size(); n_req2 = req_addr_q.size();
        step();
        redirect = 1'b0;
        wait_cons_above(n_cons, "rw_cons_wait");
        if (cons_pc_q.size() > n_cons) begin
            chk(cons_pc_q[n_cons] == 32'h200, "rw_pc", cons_pc_q[n_cons], 32'h200);
            chk(cons_dat_q[n_cons] == 32'hC0DE0200, "rw_data", cons_dat_q[n_cons], 32'hC0DE0200);
            chk(req_addr_q[n_req2] == 32'h200, "rw_req_addr", req_addr_q[n_req2], 32'h200);
        end

        // Redirect in HOLD with decode ready the same cycle.
        mem_lat = 1;
        inst_ready = 1'b0;
        wait_inst_valid("rh_wait");
        n_cons = cons_pc_q.size(); n_req = req_addr_q.size();
        redirect = 1'b1; redirect_pc = 32'h300; inst_ready = 1'b1;
        step();
        redirect = 1'b0;
        wait_cons_above(n_cons, "rh_cons_wait");
        if (cons_pc_q.size() > n_cons) begin
            chk(cons_pc_q[n_cons] == 32'h300, "rh_pc", cons_pc_q[n_cons], 32'h300);
            chk(cons_dat_q[n_cons] == 32'hC0DE0300, "rh_data", cons_dat_q[n_cons], 32'hC0DE0300);
            chk(req_addr_q[n_req] == 32'h300, "rh_req_addr", req_addr_q[n_req], 32'h300);
        end

        // Misaligned redirect from REQ.
        n_req = req_addr_q.size();
        redirect = 1'b1; redirect_pc = 32'h202;
        step();
        redirect = 1'b0;
        chk(fetch_err == 1'b1, "mis_err", 32'(fetch_err), 32'd1);
        chk(imem_req_valid == 1'b0, "mis_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (5) step();
        chk(req_addr_q.size() == n_req, "mis_no_req", req_addr_q.size(), n_req);
        chk(fetch_err == 1'b1, "mis_sticky", 32'(fetch_err), 32'd1);

        // Reset recovers; then a silent memory trips the watchdog.
        rst = 1'b1;
        step(); step();
        chk(fetch_err == 1'b0, "rst_recover_err", 32'(fetch_err), 32'd0);
        mem_dead = 1'b1;
        n_req = req_addr_q.size();
        rst = 1'b0;
        wait_req_above(n_req, "to_req_wait");
        if (req_addr_q.size() > n_req)
            chk(req_addr_q[n_req] == 32'h100, "to_req_addr", req_addr_q[n_req], 32'h100);
        for (int k = 1; k <= TO; k++) begin
            chk(fetch_err == 1'b0, "to_early", 32'(fetch_err), 32'd0);
            step();
        end
        chk(fetch_err == 1'b1, "to_err", 32'(fetch_err), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        step(); step();
        chk(fetch_err == 1'b1, "to_sticky", 32'(fetch_err), 32'd1);
        chk(imem_req_valid == 1'b0, "to_no_req", 32'(imem_req_valid), 32'd0);
        chk(req_addr_q.size() == n_req + 1, "to_req_count", req_addr_q.size(), n_req + 1);

        rst = 1'b1;
        step(); step();
        mem_dead = 1'b0;
        rst = 1'b0;
        step();
        chk(fetch_err == 1'b0, "final_no_err", 32'(fetch_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
